dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and the address check for the data-memory responder.
package dmem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Misaligned, or outside [base, base+span); addresses below base wrap high and fail too.
   function automatic logic dmem_addr_err(input logic [XLEN-1:0] addr,
                                          input logic [XLEN-1:0] base,
                                          input logic [XLEN:0]   span);
      logic [XLEN-1:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || ({1'b0, off} >= span);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: byte-enable write, registered read; contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [BE_W-1:0] be,
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
               if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request handshake, programmable wait states, byte-masked RAM access, response handshake.
// Optional DMEM_BACK2BACK_EN lets a new request be accepted on the response handshake edge.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [3:0]      req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;
   localparam state_t      NEXT_ACC  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              lat_we;
   logic [XLEN-1:0]   lat_addr;
   logic [XLEN-1:0]   lat_wdata;
   logic [BE_W-1:0]   lat_be;
   logic              rsp_err_q;
   logic              rsp_load_q;

   logic              accept;
   logic              direct_fire;
   logic              wait_fire;
   logic              acc_fire;
   logic              acc_we;
   logic [XLEN-1:0]   acc_addr;
   logic [XLEN-1:0]   acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic              acc_err;
   logic [AW-1:0]     acc_idx;
   logic [XLEN-1:0]   ram_rdata;

   always_comb begin
`ifdef DMEM_BACK2BACK_EN
      req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
`else
      req_ready = (state == ST_IDLE);
`endif
   end

   assign rsp_valid = (state == ST_RESP);
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_load_q ? ram_rdata : '0;

   // With zero wait states the access happens on the accept edge, so it uses the live request.
   assign accept      = req_valid && req_ready;
   assign direct_fire = accept && (WAIT_CYCLES == 0);
   assign wait_fire   = (state == ST_WAIT) && (wait_cnt == '0);
   assign acc_fire    = direct_fire || wait_fire;

   always_comb begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (direct_fire) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

   assign acc_err = dmem_addr_err(acc_addr, ADDR_BASE, SPAN);
   assign acc_idx = AW'((acc_addr - ADDR_BASE) >> 2);

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .en    (acc_fire && !acc_err),
      .we    (acc_we),
      .be    (acc_be),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_be     <= '0;
         rsp_err_q  <= 1'b0;
         rsp_load_q <= 1'b0;
      end else begin
         if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state    <= NEXT_ACC;
                  wait_cnt <= WAIT_INIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == '0) state <= ST_RESP;
               else                wait_cnt <= wait_cnt - 4'd1;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_err_q  <= 1'b0;
                  rsp_load_q <= 1'b0;
                  if (accept) begin
                     state    <= NEXT_ACC;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
         // Response flags for a fresh access take priority over the handshake clear.
         if (acc_fire) begin
            rsp_err_q  <= acc_err;
            rsp_load_q <= !acc_we && !acc_err;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, hand-written corner sequences, randomized traffic vs a word-array model.
module tb_dmem_responder;

`ifdef DMEM_BACK2BACK_EN
   localparam int unsigned TB_WAIT = 0;
`else
   localparam int unsigned TB_WAIT = 1;
`endif
   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_m [DEPTH];

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(TB_WAIT),
      .ADDR_BASE  (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic er);
      logic [31:0] off;
      int unsigned idx;
      off = addr - BASE;
      er  = (addr % 4 != 0) || (off >= DEPTH * 4);
      rd  = '0;
      if (!er) begin
         idx = off / 4;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            rd = mem_m[idx];
         end
      end
   endtask

   // Issues one request from IDLE; returns the response seen before the handshake.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rd, output logic er);
      int lat;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(TB_WAIT));
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, rd);
         chk("hold_err",   32'(rsp_err), 32'(er));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("post_valid",     32'(rsp_valid), 32'd0);
      chk("post_rdata",     rsp_rdata, 32'd0);
      chk("post_err",       32'(rsp_err), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mrd, exp30;
      logic        er, mer, we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int unsigned sel;

      tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
      tbl[5]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
      tbl[6]  = '{1'b1, 32'h0,   32'h12345678, 4'hF, 32'h0,        1'b0};
      tbl[7]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      tbl[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h12345678, 1'b0};
      tbl[9]  = '{1'b1, 32'h20,  32'h99999999, 4'h0, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      tbl[11] = '{1'b1, 32'h21,  32'h55555555, 4'hF, 32'h0,        1'b1};
      tbl[12] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'h0,        1'b0};
      tbl[13] = '{1'b1, 32'h30,  32'h0,        4'hF, 32'h0,        1'b0};

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err",   32'(rsp_err), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Fill every word so the model knows all contents.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         wdata = $urandom;
         model_op(1'b1, BASE + i * 4, wdata, 4'hF, mrd, mer);
         do_req(1'b1, BASE + i * 4, wdata, 4'hF, 0, rd, er);
         chk("fill_err", 32'(er), 32'd0);
      end
      // Word 63 keeps its fill value; the table load of 0xFC expects it.
      tbl[12].exp_rdata = mem_m[63];

      for (int i = 0; i < 14; i++) begin
         model_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, mrd, mer);
         do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, rd, er);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      end

      // Backpressure with an ignored store attempt while busy.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
      @(posedge clk); #1;
      req_we = 1'b1; req_wdata = 32'h0BADF00D; req_be = 4'hF;
      for (int c = 0; c < 40 && !rsp_valid; c++) begin
         @(posedge clk); #1;
      end
      for (int h = 0; h < 5; h++) begin
         chk("bp_valid",     32'(rsp_valid), 32'd1);
         chk("bp_rdata",     rsp_rdata, 32'hDEADBEEF);
         chk("bp_err",       32'(rsp_err), 32'd0);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_done_valid", 32'(rsp_valid), 32'd0);
      chk("bp_done_ready", 32'(req_ready), 32'd1);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
      chk("bp_no_store", rd, 32'hDEADBEEF);

      // Reset right after accepting a store to 0x30.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
      chk("midrst_rsp_err",   32'(rsp_err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp30 = (TB_WAIT == 0) ? 32'hCAFEF00D : 32'h0;
      if (TB_WAIT == 0) model_op(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, mrd, mer);
      do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
      chk("midrst_load30", rd, exp30);

`ifdef DMEM_BACK2BACK_EN
      begin
         logic [31:0] b2b_addr [4];
         b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h0; b2b_addr[3] = 32'h30;
         rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0;
         for (int k = 0; k < 4; k++) begin
            req_addr = b2b_addr[k];
            @(posedge clk); #1;
            model_op(1'b0, b2b_addr[k], 32'h0, 4'h0, mrd, mer);
            chk($sformatf("b2b%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("b2b%0d_rdata", k), rsp_rdata, mrd);
         end
         req_valid = 1'b0;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         chk("b2b_drain", 32'(rsp_valid), 32'd0);
      end
`endif

      // Randomized traffic against the model.
      for (int t = 0; t < 200; t++) begin
         sel   = $urandom_range(0, 9);
         we    = 1'($urandom_range(0, 1));
         wdata = $urandom;
         be    = 4'($urandom_range(0, 15));
         if (sel < 7)      addr = BASE + $urandom_range(0, DEPTH - 1) * 4;
         else if (sel < 8) addr = BASE + $urandom_range(0, DEPTH * 4 - 1) | 32'h1;
         else if (sel < 9) addr = BASE + DEPTH * 4 + $urandom_range(0, 255) * 4;
         else              addr = 32'hFFFF_FFF0 + $urandom_range(0, 3) * 4;
         model_op(we, addr, wdata, be, mrd, mer);
         do_req(we, addr, wdata, be, $urandom_range(0, 2), rd, er);
         chk($sformatf("rnd%0d_rdata", t), rd, mrd);
         chk($sformatf("rnd%0d_err", t), 32'(er), 32'(mer));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
